// File: rtl/pdn_power_sequencer_if.sv
// Bundle of the power-request side and the per-domain supply side of the
// power-domain sequencer. The sequencer is the slave; the PDN top level
// (or a bench) is the master.
//
// Handshake: pwr_req is a level request sampled only while the sequencer is
// idle (OFF or ON). Each domain step drives dom_en[i] and then waits for
// pgood[i] to follow it (rise on power-up, fall on power-down). pgood must
// already be synchronised to clk. fault_clr is a one-cycle pulse. No step
// completes until its pgood response or its timeout.
interface pdn_power_sequencer_if #(
    parameter int NUM_DOM = 6,
    parameter int IDX_W   = 3
);
    logic               pwr_req;
    logic [NUM_DOM-1:0] dom_mask;
    logic [NUM_DOM-1:0] pgood;
    logic               fault_clr;
    logic [NUM_DOM-1:0] dom_en;
    logic               all_on;
    logic               all_off;
    logic               busy;
    logic               fault;
    logic [IDX_W-1:0]   fault_idx;
    logic [3:0]         state_dbg;

    modport master (
        output pwr_req, dom_mask, pgood, fault_clr,
        input  dom_en, all_on, all_off, busy, fault, fault_idx, state_dbg
    );

    modport slave (
        input  pwr_req, dom_mask, pgood, fault_clr,
        output dom_en, all_on, all_off, busy, fault, fault_idx, state_dbg
    );
endinterface

// File: rtl/pdn_power_sequencer.sv
// Power-domain sequencer: enables the masked supply domains in ascending
// index order and disables them in descending order. Each step waits for
// the domain's power-good, then holds a settle time. Missing power-good
// (timeout) or a power-good drop while ON (brown-out) forces every domain
// off and latches the faulting index until cleared with pwr_req low.
module pdn_power_sequencer #(
    parameter int NUM_DOM     = 6,
    parameter int IDX_W       = 3,
    parameter int CNT_W       = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    pdn_power_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_OFF       = 4'd0,
        S_UP_SCAN   = 4'd1,
        S_UP_WAIT   = 4'd2,
        S_UP_SETTLE = 4'd3,
        S_ON        = 4'd4,
        S_DN_SCAN   = 4'd5,
        S_DN_WAIT   = 4'd6,
        S_DN_SETTLE = 4'd7,
        S_FAULT     = 4'd8
    } state_t;

    // Counter compare points: the counter is checked before it increments,
    // so the last counted value is N-1 for an N-cycle wait.
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOM - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [NUM_DOM-1:0] mask_q, mask_d;
    logic [NUM_DOM-1:0] dom_en_q, dom_en_d;
    logic               fault_q, fault_d;
    logic [IDX_W-1:0]   fault_idx_q, fault_idx_d;
    logic               all_on_q, all_off_q, busy_q;
    logic               bo_hit;
    logic [IDX_W-1:0]   bo_idx;

    // Saturating increment of the shared wait/settle counter.
    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Brown-out detect: lowest masked domain whose power-good has dropped.
    always_comb begin
        bo_hit = 1'b0;
        bo_idx = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (mask_q[i] && !bus.pgood[i]) begin
                bo_hit = 1'b1;
                bo_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        dom_en_d    = dom_en_q;
        fault_d     = fault_q;
        fault_idx_d = fault_idx_q;

        case (state_q)
            S_OFF: begin
                dom_en_d = '0;
                if (bus.pwr_req) begin
                    mask_d  = bus.dom_mask;
                    idx_d   = '0;
                    state_d = S_UP_SCAN;
                end
            end

            S_UP_SCAN: begin
                if (mask_q[idx_q]) begin
                    dom_en_d[idx_q] = 1'b1;
                    cnt_d           = '0;
                    state_d         = S_UP_WAIT;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_ON;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_UP_WAIT: begin
                if (bus.pgood[idx_q]) begin
                    cnt_d   = '0;
                    state_d = S_UP_SETTLE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d     = S_FAULT;
                    fault_d     = 1'b1;
                    fault_idx_d = idx_q;
                    dom_en_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_UP_SETTLE: begin
                if (cnt_q >= SETTLE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_ON;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_UP_SCAN;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_ON: begin
                if (bo_hit) begin
                    state_d     = S_FAULT;
                    fault_d     = 1'b1;
                    fault_idx_d = bo_idx;
                    dom_en_d    = '0;
                end else if (!bus.pwr_req) begin
                    idx_d   = LAST_IDX;
                    state_d = S_DN_SCAN;
                end
            end

            S_DN_SCAN: begin
                if (mask_q[idx_q]) begin
                    dom_en_d[idx_q] = 1'b0;
                    cnt_d           = '0;
                    state_d         = S_DN_WAIT;
                end else if (idx_q == '0) begin
                    state_d = S_OFF;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end

            S_DN_WAIT: begin
                if (!bus.pgood[idx_q]) begin
                    cnt_d   = '0;
                    state_d = S_DN_SETTLE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    state_d     = S_FAULT;
                    fault_d     = 1'b1;
                    fault_idx_d = idx_q;
                    dom_en_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DN_SETTLE: begin
                if (cnt_q >= SETTLE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_DN_SCAN;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_FAULT: begin
                dom_en_d = '0;
                // Clearing is only honoured once the request has been withdrawn,
                // so a fault cannot immediately restart a power-up.
                if (bus.fault_clr && !bus.pwr_req) begin
                    fault_d     = 1'b0;
                    fault_idx_d = '0;
                    state_d     = S_OFF;
                end
            end

            default: begin
                state_d  = S_OFF;
                dom_en_d = '0;
            end
        endcase
    end

    // State and registered outputs; status flags follow the next state so
    // they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            idx_q       <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            dom_en_q    <= '0;
            fault_q     <= 1'b0;
            fault_idx_q <= '0;
            all_on_q    <= 1'b0;
            all_off_q   <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            dom_en_q    <= dom_en_d;
            fault_q     <= fault_d;
            fault_idx_q <= fault_idx_d;
            all_on_q    <= (state_d == S_ON);
            all_off_q   <= (state_d == S_OFF);
            busy_q      <= (state_d != S_OFF) && (state_d != S_ON) && (state_d != S_FAULT);
        end
    end

    assign bus.dom_en    = dom_en_q;
    assign bus.all_on    = all_on_q;
    assign bus.all_off   = all_off_q;
    assign bus.busy      = busy_q;
    assign bus.fault     = fault_q;
    assign bus.fault_idx = fault_idx_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pdn_power_sequencer.sv
// Directed bench for the power-domain sequencer (6 domains, settle 4,
// timeout 8). A supply model returns pgood two clocks after dom_en, with
// per-domain kill bits for timeout and brown-out cases.
module tb_pdn_power_sequencer;

    localparam int NUM_DOM = 6;
    localparam int IDX_W   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pdn_power_sequencer_if #(.NUM_DOM(NUM_DOM), .IDX_W(IDX_W)) bus ();

    pdn_power_sequencer #(
        .NUM_DOM(NUM_DOM), .IDX_W(IDX_W), .CNT_W(8),
        .SETTLE_CYC(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and supply model.
    always #5 clk = ~clk;

    logic [NUM_DOM-1:0] pg_d1 = '0, pg_d2 = '0, pg_kill = '0;
    always @(posedge clk) begin
        pg_d1 <= bus.dom_en;
        pg_d2 <= pg_d1;
    end
    assign bus.pgood = pg_d2 & ~pg_kill;

    // Scoreboard state.
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    int rise_at[NUM_DOM];
    int fall_at[NUM_DOM];
    int on_at, off_at, fault_at;
    logic [NUM_DOM-1:0] seen_or;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Driver tasks.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.pwr_req   = 1'b0;
        bus.dom_mask  = '0;
        bus.fault_clr = 1'b0;
        pg_kill       = '0;
        tick(3);
        rst_n = 1'b1;
    endtask

    // Step the clock until a stop condition, recording edge timings relative
    // to the call. Any dom_en edge is checked against the expected queue.
    // stop_sel: 0 all_on, 1 all_off, 2 fault, 3 dom_en[1] rises.
    task automatic watch(input int max_cyc, input int stop_sel, input string tag);
        logic [NUM_DOM-1:0] prev;
        logic hit;
        prev     = bus.dom_en;
        seen_or  = bus.dom_en;
        on_at    = -1;
        off_at   = -1;
        fault_at = -1;
        hit      = 1'b0;
        for (int k = 0; k < NUM_DOM; k++) begin
            rise_at[k] = -1;
            fall_at[k] = -1;
        end
        for (int c = 1; c <= max_cyc && !hit; c++) begin
            tick(1);
            for (int k = 0; k < NUM_DOM; k++) begin
                if (bus.dom_en[k] != prev[k]) begin
                    if (bus.dom_en[k] && rise_at[k] < 0) rise_at[k] = c;
                    if (!bus.dom_en[k] && fall_at[k] < 0) fall_at[k] = c;
                    if (exp_q.size() > 0) check({tag, "_order"}, k, exp_q.pop_front());
                end
            end
            seen_or = seen_or | bus.dom_en;
            if (bus.all_on && on_at < 0) on_at = c;
            if (bus.all_off && off_at < 0) off_at = c;
            if (bus.fault && fault_at < 0) fault_at = c;
            prev = bus.dom_en;
            case (stop_sel)
                0: hit = bus.all_on;
                1: hit = bus.all_off;
                2: hit = bus.fault;
                default: hit = (rise_at[1] >= 0);
            endcase
        end
        check({tag, "_reached"}, hit, 1);
    endtask

    logic [NUM_DOM-1:0] up_seen;

    initial begin
        do_reset();

        // Reset state.
        check("rst_dom_en", bus.dom_en, 0);
        check("rst_all_on", bus.all_on, 0);
        check("rst_all_off", bus.all_off, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_fault_idx", bus.fault_idx, 0);

        // 1. Ordered power-up: dom_en[k] at cycle 2+8k, ON at cycle 49.
        bus.dom_mask = 6'h3F;
        bus.pwr_req  = 1'b1;
        for (int k = 0; k < NUM_DOM; k++) exp_q.push_back(k);
        watch(200, 0, "up");
        for (int k = 0; k < NUM_DOM; k++) check($sformatf("up_rise%0d", k), rise_at[k], 2 + 8 * k);
        check("up_on_at", on_at, 49);
        check("up_busy_on", bus.busy, 0);
        check("up_dom_en", bus.dom_en, 6'h3F);
        check("up_q_empty", exp_q.size(), 0);
        exp_q.delete();

        // 2. Masked power-down: clear 5,2,0 at cycles 2,12,21; OFF at 28.
        do_reset();
        bus.dom_mask = 6'b100101;
        bus.pwr_req  = 1'b1;
        watch(200, 0, "m_up");
        up_seen = seen_or;
        check("m_up_dom_en", bus.dom_en, 6'b100101);
        bus.pwr_req = 1'b0;
        exp_q.push_back(5);
        exp_q.push_back(2);
        exp_q.push_back(0);
        watch(200, 1, "m_dn");
        check("m_dn_fall5", fall_at[5], 2);
        check("m_dn_fall2", fall_at[2], 12);
        check("m_dn_fall0", fall_at[0], 21);
        check("m_dn_off_at", off_at, 28);
        check("m_unmasked", (up_seen | seen_or) & 6'b011010, 0);
        check("m_dn_dom_en", bus.dom_en, 0);
        check("m_dn_busy", bus.busy, 0);
        exp_q.delete();

        // 3. Timeout on domain 3: dom_en[3] at 26, fault 8 cycles later.
        do_reset();
        pg_kill      = 6'b001000;
        bus.dom_mask = 6'h3F;
        bus.pwr_req  = 1'b1;
        watch(200, 2, "to");
        check("to_rise3", rise_at[3], 26);
        check("to_delay", fault_at - rise_at[3], 8);
        check("to_fault_idx", bus.fault_idx, 3);
        check("to_dom_en", bus.dom_en, 0);
        check("to_busy", bus.busy, 0);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        tick(1);
        check("to_clr_ignored", bus.fault, 1);
        check("to_clr_ign_off", bus.all_off, 0);
        bus.pwr_req   = 1'b0;
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        check("to_clr_fault", bus.fault, 0);
        check("to_clr_all_off", bus.all_off, 1);
        check("to_clr_idx", bus.fault_idx, 0);
        pg_kill = '0;

        // 4. Brown-out on domains 4 and 2 together: lowest index reported.
        do_reset();
        bus.dom_mask = 6'h3F;
        bus.pwr_req  = 1'b1;
        watch(200, 0, "bo_up");
        pg_kill = 6'b010100;
        tick(1);
        check("bo_fault", bus.fault, 1);
        check("bo_fault_idx", bus.fault_idx, 2);
        check("bo_dom_en", bus.dom_en, 0);
        check("bo_all_on", bus.all_on, 0);
        bus.pwr_req   = 1'b0;
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        pg_kill       = '0;
        check("bo_clr_off", bus.all_off, 1);

        // 5. Request withdrawn during UP_WAIT of domain 1: ON still reached
        //    39 cycles after dom_en[1], then a full power-down.
        do_reset();
        bus.dom_mask = 6'h3F;
        bus.pwr_req  = 1'b1;
        watch(200, 3, "gl_a");
        check("gl_rise1", rise_at[1], 10);
        tick(1);
        bus.pwr_req = 1'b0;
        watch(200, 0, "gl_b");
        check("gl_on_at", on_at, 38);
        tick(1);
        check("gl_dn_busy", bus.busy, 1);
        check("gl_dn_on", bus.all_on, 0);
        watch(300, 1, "gl_c");
        check("gl_off_dom_en", bus.dom_en, 0);

        // 6. Reset pulse during UP_SETTLE of domain 0, then an empty mask.
        do_reset();
        bus.dom_mask = 6'h3F;
        bus.pwr_req  = 1'b1;
        tick(6);
        check("rs_pre_dom_en", bus.dom_en, 6'b000001);
        check("rs_pre_busy", bus.busy, 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("rs_dom_en", bus.dom_en, 0);
        check("rs_all_off", bus.all_off, 1);
        check("rs_fault", bus.fault, 0);
        bus.dom_mask = '0;
        watch(50, 0, "rs_up");
        check("rs_on_at", on_at, 7);
        check("rs_no_en", seen_or, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
